k15_scratch: RTL and testbench
==============================

Name: k15_scratch

Overview:
- Responder at the far end of a vector slice's K15 scratch and i0 scratchpad-request interfaces.
- Buffers 2*VLEN words that the slice pushes out with MV_V_K15, and returns them in order when the slice executes MV_K15_V.
- Sinks the slice's i0 requests. Requests addressed to scratch index 15 are decoded as K15 control (flush) or base-address updates.
- Sits between one slice's K15 output and the same or the neighbouring slice's K15 input.

Parameters:
- VLEN, 16, vector lane width in bits; K15 word is 2*VLEN.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AWIDTH, 11, base-address field width inside the i0 data word.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- t_k15_data  in  2*VLEN  push data from the slice's i_k15_data.
- t_k15_valid  in  1  push valid.
- t_k15_ready  out  1  push ready.
- i_k15_data  out  2*VLEN  pop data to the slice's t_k15_data.
- i_k15_valid  out  1  pop valid.
- i_k15_ready  in  1  pop ready.
- t_i0_data  in  VLEN  i0 request: [15:11] perm, [AWIDTH-1:0] baddr.
- t_i0_k  in  4  scratch index of the request.
- t_i0_valid  in  1  i0 request valid.
- t_i0_ready  out  1  i0 request ready; tied to 1.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_baddr  out  AWIDTH  last base address written via k==15.
- o_perm  out  5  last perm written via k==15.

Behaviour:
- Reset, registered outputs: o_count=0, o_baddr=0, o_perm=0. Read and write pointers are cleared.
- Reset, derived outputs: i_k15_valid=0 (FIFO empty) and t_k15_ready=1 (FIFO not full, no flush pending). i_k15_data is don't-care.
- Reset mid-transfer discards all stored words. Reset takes priority over every other event.
- Storage: DEPTH x 2*VLEN register array. Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty, and pointers wrap modulo 2*DEPTH.
- Derived flags:
  - empty = (wptr == rptr).
  - full = low bits equal and MSBs differ.
- Handshakes (standard valid/ready):
  - Push when t_k15_valid && t_k15_ready.
  - Pop when i_k15_valid && i_k15_ready.
  - i_k15_valid is not allowed to depend on i_k15_ready.
- t_k15_ready = !full && !flush_req. It is combinational from t_i0_valid and t_i0_k, so the slice's i0 and k15 paths must not form a loop.
- i_k15_valid = !empty. i_k15_data = mem[rptr] (first-word fall-through), and stays stable while valid && !ready.
- Latency: a word pushed in cycle N is presented on i_k15 in cycle N+1. No bypass in the same cycle.
- Simultaneous push and pop:
  - Allowed whenever both handshakes fire; count is unchanged.
  - When full, push is blocked by ready, so a pop alone fires.
  - When empty, pop cannot fire; a push alone fires.
- i0 decode, on every t_i0_valid (t_i0_ready always 1):
  - k==0: ignored. The slice never asserts valid with k==0; if it does, the request is accepted and dropped.
  - k in 1..14: accepted and dropped. Those indices belong to other scratch banks.
  - k==15 and perm==5'h1F: flush_req. Next cycle wptr=rptr=0 and o_count=0. Any pop handshake in the flush cycle is harmless. No push can occur in that cycle because ready=0. o_baddr and o_perm are unchanged.
  - k==15 and perm!=5'h1F: o_baddr<=baddr and o_perm<=perm next cycle. FIFO is unaffected.
- o_count update: +1 on push only, -1 on pop only, 0 otherwise or on both. It never exceeds DEPTH or goes below 0.

Test Plan:
- Basic ordering: reset 3 cycles, then push 0x00010002, 0x00030004, 0x00050006 with i_k15_ready=0. Required: o_count=3, and i_k15_data=0x00010002 from the cycle after the first push. Then assert ready for 3 cycles. Required: pops in push order, then i_k15_valid=0 and o_count=0.
- Full and wrap: push DEPTH=8 words. Required: t_k15_ready=0 at count 8. A 9th valid is held and not stored. Then interleave 1 pop and 1 push 20 times (pointer wrap). Required: data order preserved and count stays 8.
- Concurrent push/pop at count 1: push word A, then in one cycle pop A and push B. Required: count stays 1 and i_k15_data=B the next cycle.
- Flush: with 5 entries, t_i0_k=15 and t_i0_data={5'h1F,11'h000}. Required: t_k15_ready=0 in that cycle; next cycle o_count=0 and i_k15_valid=0. A push in the flush cycle is not accepted.
- Base address: t_i0_k=15, t_i0_data={5'h03,11'h2A5}. Required: o_baddr=0x2A5 and o_perm=3 next cycle, FIFO unchanged. The same data with t_i0_k=4 leaves o_baddr/o_perm unchanged and t_i0_ready=1.
- Reset mid-stream: 4 entries, assert reset 1 cycle during an active pop. Required next cycle: o_count=0, i_k15_valid=0, t_k15_ready=1, o_baddr=0.

Source files
------------

// File: rtl/k15_scratch.sv
// rtl/k15_scratch.sv - K15 scratch responder: word FIFO plus i0 control/base-address sink
//
// Purpose:
//   Sits at the far end of a vector slice's K15 scratch and i0 scratchpad
//   request interfaces. Words pushed by the slice (MV_V_K15) are buffered in a
//   first-word-fall-through FIFO and returned in order when the slice pops them
//   (MV_K15_V). i0 requests are always accepted. Requests addressed to scratch
//   index 15 either flush the FIFO (perm == 5'h1F) or latch a new base address
//   and perm field. Requests to any other index are dropped.
//
// Ports:
//   clk          in   1              rising-edge clock
//   reset        in   1              synchronous, active-high reset
//   t_k15_data   in   2*VLEN         push data
//   t_k15_valid  in   1              push valid
//   t_k15_ready  out  1              push ready (!full && !flush request)
//   i_k15_data   out  2*VLEN         pop data, head of FIFO
//   i_k15_valid  out  1              pop valid (!empty)
//   i_k15_ready  in   1              pop ready
//   t_i0_data    in   VLEN           i0 request: [15:11] perm, [AWIDTH-1:0] baddr
//   t_i0_k       in   4              i0 scratch index
//   t_i0_valid   in   1              i0 request valid
//   t_i0_ready   out  1              i0 request ready, constant 1
//   o_count      out  $clog2(DEPTH)+1 FIFO occupancy
//   o_baddr      out  AWIDTH         last base address written via index 15
//   o_perm       out  5              last perm written via index 15

module k15_scratch #(
  parameter int VLEN   = 16,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*VLEN-1:0]          t_k15_data,
  input  logic                       t_k15_valid,
  output logic                       t_k15_ready,
  output logic [2*VLEN-1:0]          i_k15_data,
  output logic                       i_k15_valid,
  input  logic                       i_k15_ready,
  input  logic [VLEN-1:0]            t_i0_data,
  input  logic [3:0]                 t_i0_k,
  input  logic                       t_i0_valid,
  output logic                       t_i0_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [AWIDTH-1:0]          o_baddr,
  output logic [4:0]                 o_perm
);

  localparam int PW = $clog2(DEPTH);

  // Pointer/count increment constant sized to avoid width mismatches.
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  localparam logic [3:0] K_CTRL     = 4'd15;
  localparam logic [4:0] PERM_FLUSH = 5'h1F;

  logic [2*VLEN-1:0] mem [DEPTH];

  // One extra MSB per pointer separates full from empty when low bits match.
  logic [PW:0] wptr;
  logic [PW:0] rptr;

  logic [4:0]        req_perm;
  logic [AWIDTH-1:0] req_baddr;
  logic              ctrl_hit;
  logic              flush_req;
  logic              baddr_wr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // i0 decode: only index 15 carries anything for this block.
  assign req_perm  = t_i0_data[15:11];
  assign req_baddr = t_i0_data[AWIDTH-1:0];
  assign ctrl_hit  = t_i0_valid && (t_i0_k == K_CTRL);
  assign flush_req = ctrl_hit && (req_perm == PERM_FLUSH);
  assign baddr_wr  = ctrl_hit && (req_perm != PERM_FLUSH);

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);

  // Ready is dropped during a flush so no word can sneak in behind the clear.
  assign t_k15_ready = !full && !flush_req;
  assign i_k15_valid = !empty;
  assign i_k15_data  = mem[rptr[PW-1:0]];
  assign t_i0_ready  = 1'b1;

  assign push = t_k15_valid && t_k15_ready;
  assign pop  = i_k15_valid && i_k15_ready;

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[PW-1:0]] <= t_k15_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else if (flush_req) begin
      // A pop in the flush cycle is discarded along with everything else.
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ONE;
      end
      if (pop) begin
        rptr <= rptr + ONE;
      end
      if (push && !pop) begin
        o_count <= o_count + ONE;
      end else if (pop && !push) begin
        o_count <= o_count - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_baddr <= '0;
      o_perm  <= '0;
    end else if (baddr_wr) begin
      o_baddr <= req_baddr;
      o_perm  <= req_perm;
    end
  end

endmodule

// File: tb/tb_k15_scratch.sv
// tb/tb_k15_scratch.sv - self-checking bench for k15_scratch

module tb_k15_scratch;

  localparam int VLEN   = 16;
  localparam int DEPTH  = 8;
  localparam int AWIDTH = 11;

  logic              clk;
  logic              reset;
  logic [31:0]       t_k15_data;
  logic              t_k15_valid;
  logic              t_k15_ready;
  logic [31:0]       i_k15_data;
  logic              i_k15_valid;
  logic              i_k15_ready;
  logic [15:0]       t_i0_data;
  logic [3:0]        t_i0_k;
  logic              t_i0_valid;
  logic              t_i0_ready;
  logic [3:0]        o_count;
  logic [10:0]       o_baddr;
  logic [4:0]        o_perm;

  int tests;
  int fails;

  logic [31:0] sb_q[$];
  logic [31:0] exp_w;

  k15_scratch #(.VLEN(VLEN), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .t_k15_data  (t_k15_data),
    .t_k15_valid (t_k15_valid),
    .t_k15_ready (t_k15_ready),
    .i_k15_data  (i_k15_data),
    .i_k15_valid (i_k15_valid),
    .i_k15_ready (i_k15_ready),
    .t_i0_data   (t_i0_data),
    .t_i0_k      (t_i0_k),
    .t_i0_valid  (t_i0_valid),
    .t_i0_ready  (t_i0_ready),
    .o_count     (o_count),
    .o_baddr     (o_baddr),
    .o_perm      (o_perm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven at posedge+1; handshakes are sampled at posedge+4.
  // Accepted pushes go onto the scoreboard; pops are compared by the callers.
  task automatic tick(output bit pushed, output bit popped, output logic [31:0] pdata);
    #3;
    pushed = t_k15_valid && t_k15_ready;
    popped = i_k15_valid && i_k15_ready;
    pdata  = i_k15_data;
    if (pushed && !reset) sb_q.push_back(t_k15_data);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_k15_valid = 1'b0;
    t_k15_data  = '0;
    i_k15_ready = 1'b0;
    t_i0_valid  = 1'b0;
    t_i0_k      = 4'd0;
    t_i0_data   = '0;
  endtask

  task automatic push_word(input logic [31:0] w);
    bit pu, po;
    logic [31:0] pd;
    t_k15_valid = 1'b1;
    t_k15_data  = w;
    i_k15_ready = 1'b0;
    tick(pu, po, pd);
    t_k15_valid = 1'b0;
    tests++;
    if (pu !== 1'b1) begin
      fails++;
      $display("FAIL push_accept: got %0b expected 1 (word %h)", pu, w);
    end
  endtask

  task automatic pop_check(input string name);
    bit pu, po;
    logic [31:0] pd;
    t_k15_valid = 1'b0;
    i_k15_ready = 1'b1;
    tick(pu, po, pd);
    i_k15_ready = 1'b0;
    tests++;
    if (po !== 1'b1) begin
      fails++;
      $display("FAIL %s_pop_fired: got %0b expected 1", name, po);
    end else begin
      exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      tests++;
      if (pd !== exp_w) begin
        fails++;
        $display("FAIL %s_pop_data: got %h expected %h", name, pd, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    bit pu, po;
    logic [31:0] pd;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick(pu, po, pd);
    reset = 1'b0;
    tests++;
    if (o_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    tests++;
    if (i_k15_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", i_k15_valid); end
    tests++;
    if (t_k15_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", t_k15_ready); end
    tests++;
    if (o_baddr !== 11'd0 || o_perm !== 5'd0) begin
      fails++; $display("FAIL reset_baddr_perm: got %h/%h expected 0/0", o_baddr, o_perm);
    end
    tests++;
    if (t_i0_ready !== 1'b1) begin fails++; $display("FAIL reset_i0_ready: got %0b expected 1", t_i0_ready); end
  endtask

  task automatic test_basic();
    push_word(32'h0001_0002);
    tests++;
    if (i_k15_valid !== 1'b1 || i_k15_data !== 32'h0001_0002) begin
      fails++; $display("FAIL basic_fwft: got v=%0b d=%h expected v=1 d=00010002", i_k15_valid, i_k15_data);
    end
    push_word(32'h0003_0004);
    push_word(32'h0005_0006);
    tests++;
    if (o_count !== 4'd3) begin fails++; $display("FAIL basic_count3: got %0d expected 3", o_count); end
    tests++;
    if (i_k15_data !== 32'h0001_0002) begin fails++; $display("FAIL basic_head_stable: got %h expected 00010002", i_k15_data); end
    repeat (3) pop_check("basic");
    tests++;
    if (i_k15_valid !== 1'b0 || o_count !== 4'd0) begin
      fails++; $display("FAIL basic_drained: got v=%0b c=%0d expected v=0 c=0", i_k15_valid, o_count);
    end
  endtask

  task automatic test_full_wrap();
    bit pu, po;
    logic [31:0] pd;
    for (int i = 0; i < DEPTH; i++) push_word($urandom());
    tests++;
    if (o_count !== 4'd8) begin fails++; $display("FAIL full_count: got %0d expected 8", o_count); end
    tests++;
    if (t_k15_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b expected 0", t_k15_ready); end
    t_k15_valid = 1'b1;
    t_k15_data  = 32'hBAD0_0009;
    tick(pu, po, pd);
    t_k15_valid = 1'b0;
    tests++;
    if (pu !== 1'b0 || o_count !== 4'd8) begin
      fails++; $display("FAIL full_ninth_held: got push=%0b c=%0d expected push=0 c=8", pu, o_count);
    end
    for (int i = 0; i < 20; i++) begin
      pop_check("wrap");
      push_word($urandom());
      tests++;
      if (o_count !== 4'd8) begin fails++; $display("FAIL wrap_count_%0d: got %0d expected 8", i, o_count); end
    end
    repeat (DEPTH) pop_check("wrap_drain");
    tests++;
    if (o_count !== 4'd0 || i_k15_valid !== 1'b0) begin
      fails++; $display("FAIL wrap_empty: got c=%0d v=%0b expected c=0 v=0", o_count, i_k15_valid);
    end
  endtask

  task automatic test_concurrent();
    bit pu, po;
    logic [31:0] pd;
    push_word(32'hAAAA_0001);
    t_k15_valid = 1'b1;
    t_k15_data  = 32'hBBBB_0002;
    i_k15_ready = 1'b1;
    tick(pu, po, pd);
    t_k15_valid = 1'b0;
    i_k15_ready = 1'b0;
    tests++;
    if (pu !== 1'b1 || po !== 1'b1) begin
      fails++; $display("FAIL conc_both_fire: got push=%0b pop=%0b expected 1/1", pu, po);
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    tests++;
    if (pd !== exp_w) begin fails++; $display("FAIL conc_pop_data: got %h expected %h", pd, exp_w); end
    tests++;
    if (o_count !== 4'd1) begin fails++; $display("FAIL conc_count: got %0d expected 1", o_count); end
    tests++;
    if (i_k15_data !== 32'hBBBB_0002) begin fails++; $display("FAIL conc_next_head: got %h expected bbbb0002", i_k15_data); end
    pop_check("conc_drain");
  endtask

  task automatic test_flush();
    bit pu, po;
    logic [31:0] pd;
    for (int i = 0; i < 5; i++) push_word(32'hF000_0000 + i);
    t_i0_valid  = 1'b1;
    t_i0_k      = 4'd15;
    t_i0_data   = {5'h1F, 11'h000};
    t_k15_valid = 1'b1;
    t_k15_data  = 32'hC0FF_EE00;
    i_k15_ready = 1'b1;
    #2;
    tests++;
    if (t_k15_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %0b expected 0", t_k15_ready); end
    #0 tick(pu, po, pd);
    idle_inputs();
    sb_q.delete();
    tests++;
    if (pu !== 1'b0) begin fails++; $display("FAIL flush_push_blocked: got %0b expected 0", pu); end
    tests++;
    if (o_count !== 4'd0 || i_k15_valid !== 1'b0) begin
      fails++; $display("FAIL flush_cleared: got c=%0d v=%0b expected c=0 v=0", o_count, i_k15_valid);
    end
    tests++;
    if (o_baddr !== 11'd0 || o_perm !== 5'd0) begin
      fails++; $display("FAIL flush_baddr_kept: got %h/%h expected 0/0", o_baddr, o_perm);
    end
    push_word(32'h1234_5678);
    pop_check("post_flush");
  endtask

  task automatic test_baddr();
    bit pu, po;
    logic [31:0] pd;
    push_word(32'h0BAD_0001);
    push_word(32'h0BAD_0002);
    t_i0_valid = 1'b1;
    t_i0_k     = 4'd15;
    t_i0_data  = {5'h03, 11'h2A5};
    tick(pu, po, pd);
    tests++;
    if (o_baddr !== 11'h2A5 || o_perm !== 5'h03) begin
      fails++; $display("FAIL baddr_write: got %h/%h expected 2a5/03", o_baddr, o_perm);
    end
    tests++;
    if (o_count !== 4'd2) begin fails++; $display("FAIL baddr_fifo_kept: got %0d expected 2", o_count); end
    t_i0_k    = 4'd4;
    t_i0_data = {5'h07, 11'h111};
    #2;
    tests++;
    if (t_i0_ready !== 1'b1) begin fails++; $display("FAIL baddr_i0_ready: got %0b expected 1", t_i0_ready); end
    #0 tick(pu, po, pd);
    t_i0_k    = 4'd0;
    t_i0_data = {5'h1F, 11'h7FF};
    tick(pu, po, pd);
    t_i0_valid = 1'b0;
    tests++;
    if (o_baddr !== 11'h2A5 || o_perm !== 5'h03) begin
      fails++; $display("FAIL baddr_other_k: got %h/%h expected 2a5/03", o_baddr, o_perm);
    end
    tests++;
    if (o_count !== 4'd2) begin fails++; $display("FAIL baddr_other_k_fifo: got %0d expected 2", o_count); end
    repeat (2) pop_check("baddr_drain");
  endtask

  task automatic test_reset_mid();
    bit pu, po;
    logic [31:0] pd;
    for (int i = 0; i < 4; i++) push_word(32'h5000_0000 + i);
    i_k15_ready = 1'b1;
    reset       = 1'b1;
    tick(pu, po, pd);
    reset       = 1'b0;
    i_k15_ready = 1'b0;
    sb_q.delete();
    tests++;
    if (o_count !== 4'd0 || i_k15_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_cleared: got c=%0d v=%0b expected c=0 v=0", o_count, i_k15_valid);
    end
    tests++;
    if (t_k15_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %0b expected 1", t_k15_ready); end
    tests++;
    if (o_baddr !== 11'd0 || o_perm !== 5'd0) begin
      fails++; $display("FAIL rstmid_baddr: got %h/%h expected 0/0", o_baddr, o_perm);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_full_wrap();
    test_concurrent();
    test_flush();
    test_baddr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
